// File: rtl/spi_target_pkg.sv
// Shared types and status-bit positions for the SPI mode-0 target.
package spi_target_pkg;
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_tgt_state_e;

    localparam int RX_OVR  = 0;
    localparam int TX_UND  = 1;
    localparam int FRM_ERR = 2;
endpackage

// File: rtl/spi_target_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module spi_target_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    // Head reads as zero while empty so the output has a defined reset value.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with oversampled inputs, RX/TX FIFOs and sticky status.
// Optional `define SPI_TARGET_IRQ_EN adds the sticky tgt_irq output.
module spi_target #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic       tgt_wr,
    input  logic [7:0] tgt_din,
    input  logic       tgt_rd,
    output logic [7:0] tgt_dout,
    output logic       tgt_rx_avail,
    output logic       tgt_tx_full,
    output logic       tgt_tx_empty,
    output logic       tgt_busy,
    output logic [2:0] tgt_status,
    input  logic       tgt_clr
`ifdef SPI_TARGET_IRQ_EN
    ,
    output logic       tgt_irq
`endif
);
    import spi_target_pkg::*;

    logic sck_s1_q, sck_s2_q, sck_h_q;
    logic cs_s1_q, cs_s2_q, cs_h_q;
    logic mosi_s1_q, mosi_s2_q;
    logic post_q, arm_q;

    spi_tgt_state_e state_q;
    logic       miso_q, oe_q, started_q, und_pend_q;
    logic [7:0] tx_sh_q;
    logic [6:0] rx_sh_q;
    logic [2:0] bit_cnt_q;
    logic [2:0] status_q, status_d, status_set;

    logic       sck_rise, sck_fall, cs_fall, cs_rise, active;
    logic       load_evt, tx_pop, rx_push;
    logic [7:0] load_byte, rx_byte, tx_dout;
    logic       tx_full, tx_empty, rx_full, rx_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_h_q   <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_h_q    <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            post_q    <= 1'b0;
            arm_q     <= 1'b0;
        end else begin
            sck_s1_q  <= spi_sck;
            sck_s2_q  <= sck_s1_q;
            sck_h_q   <= sck_s2_q;
            cs_s1_q   <= spi_cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_h_q    <= cs_s2_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
            post_q    <= 1'b1;
            // Arm only once cs_n has really been sampled high after reset, so a
            // cs_n held low through reset is not mistaken for a new frame.
            arm_q     <= arm_q | (post_q & cs_s1_q);
        end
    end

    assign sck_rise = sck_s2_q & ~sck_h_q;
    assign sck_fall = ~sck_s2_q & sck_h_q;
    assign cs_fall  = arm_q & ~cs_s2_q & cs_h_q;
    assign cs_rise  = cs_s2_q & ~cs_h_q;
    assign active   = (state_q == ACTIVE);

    assign load_evt  = active ? (~cs_rise & sck_fall & started_q & (bit_cnt_q == 3'd0)) : cs_fall;
    assign tx_pop    = load_evt & ~tx_empty;
    assign load_byte = tx_empty ? IDLE_BYTE : tx_dout;
    assign rx_push   = active & ~cs_rise & sck_rise & (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_sh_q, mosi_s2_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            miso_q     <= 1'b1;
            oe_q       <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            bit_cnt_q  <= '0;
            started_q  <= 1'b0;
            und_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q    <= ACTIVE;
                        oe_q       <= 1'b1;
                        miso_q     <= load_byte[7];
                        tx_sh_q    <= {load_byte[6:0], 1'b0};
                        bit_cnt_q  <= '0;
                        started_q  <= 1'b0;
                        und_pend_q <= tx_empty;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q    <= IDLE;
                        oe_q       <= 1'b0;
                        bit_cnt_q  <= '0;
                        und_pend_q <= 1'b0;
                    end else if (sck_rise) begin
                        rx_sh_q    <= {rx_sh_q[5:0], mosi_s2_q};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        started_q  <= 1'b1;
                        und_pend_q <= 1'b0;
                    end else if (sck_fall) begin
                        if (load_evt) begin
                            miso_q     <= load_byte[7];
                            tx_sh_q    <= {load_byte[6:0], 1'b0};
                            und_pend_q <= tx_empty;
                        end else begin
                            miso_q  <= tx_sh_q[7];
                            tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    // An idle fill byte only counts as an underrun once a clock edge actually
    // shifts it out; the trailing sck fall at the end of a frame is harmless.
    always_comb begin
        status_set          = '0;
        status_set[RX_OVR]  = rx_push & rx_full & ~tgt_rd;
        status_set[TX_UND]  = active & ~cs_rise & sck_rise & und_pend_q;
        status_set[FRM_ERR] = active & cs_rise & (bit_cnt_q != 3'd0);
        status_d            = (tgt_clr ? 3'b000 : status_q) | status_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_q <= '0;
        else        status_q <= status_d;
    end

`ifdef SPI_TARGET_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = (tgt_clr ? 1'b0 : irq_q) | (cs_rise & ~rx_empty) | (|status_set);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign tgt_irq = irq_q;
`endif

    spi_target_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (rx_push),
        .din_i  (rx_byte),
        .pop_i  (tgt_rd),
        .dout_o (tgt_dout),
        .full_o (rx_full),
        .empty_o(rx_empty)
    );

    spi_target_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (tgt_wr),
        .din_i  (tgt_din),
        .pop_i  (tx_pop),
        .dout_o (tx_dout),
        .full_o (tx_full),
        .empty_o(tx_empty)
    );

    assign spi_miso     = miso_q;
    assign spi_miso_oe  = oe_q;
    assign tgt_rx_avail = ~rx_empty;
    assign tgt_tx_full  = tx_full;
    assign tgt_tx_empty = tx_empty;
    assign tgt_busy     = ~cs_s2_q;
    assign tgt_status   = status_q;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: acts as the SPI master and the local MMIO host.
module tb_spi_target;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic       tgt_wr = 1'b0;
    logic [7:0] tgt_din = 8'h00;
    logic       tgt_rd = 1'b0;
    logic [7:0] tgt_dout;
    logic       tgt_rx_avail, tgt_tx_full, tgt_tx_empty, tgt_busy;
    logic [2:0] tgt_status;
    logic       tgt_clr = 1'b0;
`ifdef SPI_TARGET_IRQ_EN
    logic       tgt_irq;
`endif

    int tests_run = 0;
    int fails = 0;

    spi_target #(.DEPTH(8), .IDLE_BYTE(8'hFF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck     (spi_sck),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tgt_wr      (tgt_wr),
        .tgt_din     (tgt_din),
        .tgt_rd      (tgt_rd),
        .tgt_dout    (tgt_dout),
        .tgt_rx_avail(tgt_rx_avail),
        .tgt_tx_full (tgt_tx_full),
        .tgt_tx_empty(tgt_tx_empty),
        .tgt_busy    (tgt_busy),
        .tgt_status  (tgt_status),
        .tgt_clr     (tgt_clr)
`ifdef SPI_TARGET_IRQ_EN
        ,
        .tgt_irq     (tgt_irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        clks(8);
    endtask

    task automatic cs_high();
        clks(4);
        spi_cs_n = 1'b1;
        clks(8);
    endtask

    // Mode 0: drive MOSI while sck is low, sample MISO on the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            clks(4);
            spi_sck = 1'b1;
            rx[i] = spi_miso;
            clks(4);
            spi_sck = 1'b0;
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        tgt_wr = 1'b1;
        tgt_din = b;
        clks(1);
        tgt_wr = 1'b0;
    endtask

    task automatic pop_rx();
        tgt_rd = 1'b1;
        clks(1);
        tgt_rd = 1'b0;
    endtask

    task automatic clear_status();
        tgt_clr = 1'b1;
        clks(1);
        tgt_clr = 1'b0;
    endtask

    task automatic test_reset();
        clks(2);
        tests_run++; if (spi_miso !== 1'b1) begin fails++; $display("FAIL reset_miso: got %b want 1", spi_miso); end
        tests_run++; if (spi_miso_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
        tests_run++; if (tgt_dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", tgt_dout); end
        tests_run++; if (tgt_rx_avail !== 1'b0) begin fails++; $display("FAIL reset_rx_avail: got %b want 0", tgt_rx_avail); end
        tests_run++; if (tgt_tx_full !== 1'b0) begin fails++; $display("FAIL reset_tx_full: got %b want 0", tgt_tx_full); end
        tests_run++; if (tgt_tx_empty !== 1'b1) begin fails++; $display("FAIL reset_tx_empty: got %b want 1", tgt_tx_empty); end
        tests_run++; if (tgt_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", tgt_busy); end
        tests_run++; if (tgt_status !== 3'b000) begin fails++; $display("FAIL reset_status: got %b want 000", tgt_status); end
        rst_n = 1'b1;
        clks(4);
    endtask

    task automatic test_basic();
        logic [7:0] r0, r1;
        push_tx(8'hA5);
        push_tx(8'h3C);
        tests_run++; if (tgt_tx_empty !== 1'b0) begin fails++; $display("FAIL basic_tx_empty_pre: got %b want 0", tgt_tx_empty); end
        cs_low();
        tests_run++; if (tgt_busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", tgt_busy); end
        tests_run++; if (spi_miso_oe !== 1'b1) begin fails++; $display("FAIL basic_oe: got %b want 1", spi_miso_oe); end
        spi_bits(8'h12, 8, r0);
        spi_bits(8'h34, 8, r1);
        cs_high();
        tests_run++; if (r0 !== 8'hA5) begin fails++; $display("FAIL basic_miso0: got %h want a5", r0); end
        tests_run++; if (r1 !== 8'h3C) begin fails++; $display("FAIL basic_miso1: got %h want 3c", r1); end
        tests_run++; if (spi_miso_oe !== 1'b0) begin fails++; $display("FAIL basic_oe_off: got %b want 0", spi_miso_oe); end
        tests_run++; if (tgt_rx_avail !== 1'b1) begin fails++; $display("FAIL basic_rx_avail: got %b want 1", tgt_rx_avail); end
        tests_run++; if (tgt_dout !== 8'h12) begin fails++; $display("FAIL basic_rx0: got %h want 12", tgt_dout); end
        pop_rx();
        tests_run++; if (tgt_dout !== 8'h34) begin fails++; $display("FAIL basic_rx1: got %h want 34", tgt_dout); end
        pop_rx();
        tests_run++; if (tgt_rx_avail !== 1'b0) begin fails++; $display("FAIL basic_rx_drained: got %b want 0", tgt_rx_avail); end
        tests_run++; if (tgt_status !== 3'b000) begin fails++; $display("FAIL basic_status: got %b want 000", tgt_status); end
        tests_run++; if (tgt_tx_empty !== 1'b1) begin fails++; $display("FAIL basic_tx_empty_post: got %b want 1", tgt_tx_empty); end
    endtask

    task automatic test_underrun();
        logic [7:0] r;
        cs_low();
        spi_bits(8'h7E, 8, r);
        cs_high();
        tests_run++; if (r !== 8'hFF) begin fails++; $display("FAIL underrun_miso: got %h want ff", r); end
        tests_run++; if (tgt_status !== 3'b010) begin fails++; $display("FAIL underrun_status: got %b want 010", tgt_status); end
        tests_run++; if (tgt_dout !== 8'h7E) begin fails++; $display("FAIL underrun_rx: got %h want 7e", tgt_dout); end
        pop_rx();
        clear_status();
        tests_run++; if (tgt_status !== 3'b000) begin fails++; $display("FAIL underrun_clr: got %b want 000", tgt_status); end
    endtask

    task automatic test_overrun();
        logic [7:0] r;
        cs_low();
        for (int i = 0; i < 9; i++) spi_bits(8'h01 + 8'(i), 8, r);
        cs_high();
        tests_run++; if (tgt_status !== 3'b011) begin fails++; $display("FAIL overrun_status: got %b want 011", tgt_status); end
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (tgt_dout !== 8'h01 + 8'(k)) begin
                fails++; $display("FAIL overrun_rx%0d: got %h want %h", k, tgt_dout, 8'h01 + 8'(k));
            end
            pop_rx();
        end
        tests_run++; if (tgt_rx_avail !== 1'b0) begin fails++; $display("FAIL overrun_drained: got %b want 0", tgt_rx_avail); end
        pop_rx();
        tests_run++; if (tgt_rx_avail !== 1'b0) begin fails++; $display("FAIL overrun_pop_empty: got %b want 0", tgt_rx_avail); end
        clear_status();
    endtask

    task automatic test_tx_full();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) push_tx(8'h10 + 8'(i));
        tests_run++; if (tgt_tx_full !== 1'b1) begin fails++; $display("FAIL txfull_flag: got %b want 1", tgt_tx_full); end
        push_tx(8'hEE);
        cs_low();
        for (int i = 0; i < 8; i++) begin
            spi_bits(8'hC0 + 8'(i), 8, r);
            tests_run++;
            if (r !== 8'h10 + 8'(i)) begin
                fails++; $display("FAIL txfull_miso%0d: got %h want %h", i, r, 8'h10 + 8'(i));
            end
        end
        cs_high();
        tests_run++; if (tgt_status !== 3'b000) begin fails++; $display("FAIL txfull_status: got %b want 000", tgt_status); end
        tests_run++; if (tgt_dout !== 8'hC0) begin fails++; $display("FAIL txfull_rx0: got %h want c0", tgt_dout); end
        for (int i = 0; i < 8; i++) pop_rx();
        tests_run++; if (tgt_rx_avail !== 1'b0) begin fails++; $display("FAIL txfull_drained: got %b want 0", tgt_rx_avail); end
    endtask

    task automatic test_frame_err();
        logic [7:0] r;
        cs_low();
        spi_bits(8'hAA, 5, r);
        cs_high();
        tests_run++; if (tgt_rx_avail !== 1'b0) begin fails++; $display("FAIL frmerr_no_push: got %b want 0", tgt_rx_avail); end
        tests_run++; if (tgt_status !== 3'b110) begin fails++; $display("FAIL frmerr_status: got %b want 110", tgt_status); end
        clear_status();
        cs_low();
        spi_bits(8'h5A, 8, r);
        cs_high();
        tests_run++; if (tgt_dout !== 8'h5A) begin fails++; $display("FAIL frmerr_next_rx: got %h want 5a", tgt_dout); end
        tests_run++; if (tgt_status !== 3'b010) begin fails++; $display("FAIL frmerr_next_status: got %b want 010", tgt_status); end
        pop_rx();
        clear_status();
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        cs_low();
        spi_bits(8'hFF, 3, r);
        tests_run++; if (tgt_status !== 3'b010) begin fails++; $display("FAIL rstmid_pre_status: got %b want 010", tgt_status); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (spi_miso !== 1'b1) begin fails++; $display("FAIL rstmid_miso: got %b want 1", spi_miso); end
        tests_run++; if (spi_miso_oe !== 1'b0) begin fails++; $display("FAIL rstmid_oe: got %b want 0", spi_miso_oe); end
        tests_run++; if (tgt_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", tgt_busy); end
        tests_run++; if (tgt_status !== 3'b000) begin fails++; $display("FAIL rstmid_status: got %b want 000", tgt_status); end
        tests_run++; if (tgt_tx_empty !== 1'b1) begin fails++; $display("FAIL rstmid_tx_empty: got %b want 1", tgt_tx_empty); end
        spi_cs_n = 1'b1;
        clks(3);
        rst_n = 1'b1;
        clks(4);
        cs_low();
        spi_bits(8'hC3, 8, r);
        cs_high();
        tests_run++; if (tgt_dout !== 8'hC3) begin fails++; $display("FAIL rstmid_next_rx: got %h want c3", tgt_dout); end
        pop_rx();
        clear_status();
    endtask

`ifdef SPI_TARGET_IRQ_EN
    task automatic test_irq();
        logic [7:0] r;
        clear_status();
        tests_run++; if (tgt_irq !== 1'b0) begin fails++; $display("FAIL irq_idle: got %b want 0", tgt_irq); end
        push_tx(8'h55);
        cs_low();
        spi_bits(8'h66, 8, r);
        tests_run++; if (tgt_irq !== 1'b0) begin fails++; $display("FAIL irq_before_rise: got %b want 0", tgt_irq); end
        cs_high();
        tests_run++; if (tgt_irq !== 1'b1) begin fails++; $display("FAIL irq_set: got %b want 1", tgt_irq); end
        clear_status();
        tests_run++; if (tgt_irq !== 1'b0) begin fails++; $display("FAIL irq_clr: got %b want 0", tgt_irq); end
        pop_rx();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_overrun();
        test_tx_full();
        test_frame_err();
        test_reset_mid();
`ifdef SPI_TARGET_IRQ_EN
        test_irq();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", tests_run);
        $fatal(1);
    end
endmodule
